// File: rtl/core_pkg.sv
// core_pkg
// Definitions shared by the data-memory responder and its byte banks:
//   - HALT_ADDR_DEFAULT : write address whose word raises the sticky halt flag
//   - dmem_state_e      : responder FSM states (idle / busy)
//   - lane constants    : where each byte bank sits inside the 16-bit data word
// The memory is big-endian: the even byte lives in data[15:8] and the odd
// byte lives in data[7:0].
package core_pkg;

  localparam logic [15:0] HALT_ADDR_DEFAULT = 16'hFFFE;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } dmem_state_e;

  // Bit positions of the two byte lanes inside a 16-bit word.
  localparam int EVEN_LANE_LSB = 8;
  localparam int ODD_LANE_LSB  = 0;
  localparam int LANE_W        = 8;

endpackage

// File: rtl/dmem_byte_bank.sv
// dmem_byte_bank
// One byte-wide lane of data memory: 2^INDEX_W entries of 8 bits.
// Writes happen on the rising clock edge; the read port is combinational so
// the responder can capture read data into its own output register on the
// same edge that performs the access. Contents are never reset.
// Ports:
//   clk   : rising-edge clock
//   we    : write enable for this lane
//   index : entry selected for both read and write
//   wdata : byte to store when we=1
//   rdata : byte currently stored at index
module dmem_byte_bank #(
  parameter int INDEX_W = 15
) (
  input  logic               clk,
  input  logic               we,
  input  logic [INDEX_W-1:0] index,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [2**INDEX_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[index] <= wdata;
    end
  end

  assign rdata = mem[index];

endmodule

// File: rtl/d_mem_responder.sv
// d_mem_responder
// Simple data-memory slave for a 16-bit core. A request is accepted in IDLE,
// held in internal registers, then the responder stays BUSY for
// WAIT_CYCLES+1 cycles and performs the access on the final busy edge.
// Storage is split into an even and an odd byte bank (big-endian word layout).
// Any write to the word holding HALT_ADDR sets a sticky halt flag.
// Ports:
//   clk            : rising-edge clock
//   rst            : synchronous active-high reset
//   d_mem_assert   : request valid
//   d_mem_cmd      : 1 = write, 0 = read
//   d_mem_be0      : byte enable, even byte
//   d_mem_be1      : byte enable, odd byte
//   d_mem_addr     : byte address
//   d_mem_data_out : write data from the core
//   d_mem_data_in  : registered read data to the core
//   d_mem_rdy      : 1 while idle (request will be accepted)
//   halt           : sticky, set by a write to HALT_ADDR
module d_mem_responder
  import core_pkg::*;
#(
  parameter int          ADDR_W      = 16,
  parameter int          WAIT_CYCLES = 0,
  parameter logic [15:0] HALT_ADDR   = HALT_ADDR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_mem_assert,
  input  logic        d_mem_cmd,
  input  logic        d_mem_be0,
  input  logic        d_mem_be1,
  input  logic [15:0] d_mem_addr,
  input  logic [15:0] d_mem_data_out,
  output logic [15:0] d_mem_data_in,
  output logic        d_mem_rdy,
  output logic        halt
);

  localparam int          INDEX_W  = ADDR_W - 1;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  dmem_state_e  state_q, state_d;
  logic [3:0]   cnt_q, cnt_d;
  logic [15:0]  addr_q, addr_d;
  logic         cmd_q, cmd_d;
  logic         be0_q, be0_d;
  logic         be1_q, be1_d;
  logic [15:0]  wdata_q, wdata_d;
  logic [15:0]  data_in_q, data_in_d;
  logic         halt_q, halt_d;

  logic               access;
  logic               word_acc;
  logic               byte_acc;
  logic [INDEX_W-1:0] bank_index;
  logic               even_we, odd_we;
  logic [7:0]         even_wdata, odd_wdata;
  logic [7:0]         even_rdata, odd_rdata;

  // The access edge is the last busy cycle. Reset gates the bank writes
  // because the banks themselves are never reset.
  assign access     = (state_q == ST_BUSY) && (cnt_q == 4'd0) && !rst;
  assign word_acc   = be0_q && be1_q;
  assign byte_acc   = be0_q ^ be1_q;
  assign bank_index = addr_q[ADDR_W-1:1];

  // Byte accesses pick the lane from addr[0]; word accesses hit both lanes.
  assign even_we    = access && cmd_q && (word_acc || (byte_acc && !addr_q[0]));
  assign odd_we     = access && cmd_q && (word_acc || (byte_acc &&  addr_q[0]));
  assign even_wdata = word_acc ? wdata_q[EVEN_LANE_LSB +: LANE_W]
                               : wdata_q[ODD_LANE_LSB +: LANE_W];
  assign odd_wdata  = wdata_q[ODD_LANE_LSB +: LANE_W];

  dmem_byte_bank #(.INDEX_W(INDEX_W)) u_even_bank (
    .clk   (clk),
    .we    (even_we),
    .index (bank_index),
    .wdata (even_wdata),
    .rdata (even_rdata)
  );

  dmem_byte_bank #(.INDEX_W(INDEX_W)) u_odd_bank (
    .clk   (clk),
    .we    (odd_we),
    .index (bank_index),
    .wdata (odd_wdata),
    .rdata (odd_rdata)
  );

  // Next-state, request capture, read-data and halt logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    cmd_d     = cmd_q;
    be0_d     = be0_q;
    be1_d     = be1_q;
    wdata_d   = wdata_q;
    data_in_d = data_in_q;
    halt_d    = halt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (d_mem_assert) begin
          state_d = ST_BUSY;
          cnt_d   = WAIT_INIT;
          addr_d  = d_mem_addr;
          cmd_d   = d_mem_cmd;
          be0_d   = d_mem_be0;
          be1_d   = d_mem_be1;
          wdata_d = d_mem_data_out;
        end
      end
      ST_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_IDLE;
          if (cmd_q) begin
            // Halt compares the full 16-bit word address, not just the
            // bits that reach storage.
            if (addr_q[15:1] == HALT_ADDR[15:1]) begin
              halt_d = 1'b1;
            end
          end else if (word_acc) begin
            data_in_d = {even_rdata, odd_rdata};
          end else if (byte_acc) begin
            data_in_d = {8'h00, (addr_q[0] ? odd_rdata : even_rdata)};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= 16'h0000;
      cmd_q     <= 1'b0;
      be0_q     <= 1'b0;
      be1_q     <= 1'b0;
      wdata_q   <= 16'h0000;
      data_in_q <= 16'h0000;
      halt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      cmd_q     <= cmd_d;
      be0_q     <= be0_d;
      be1_q     <= be1_d;
      wdata_q   <= wdata_d;
      data_in_q <= data_in_d;
      halt_q    <= halt_d;
    end
  end

  assign d_mem_rdy     = (state_q == ST_IDLE);
  assign d_mem_data_in = data_in_q;
  assign halt          = halt_q;

endmodule

// File: tb/tb_d_mem_responder.sv
// tb_d_mem_responder
// Drives two responders in lockstep: one with no wait states and one with
// three. Each request pushes the expected data_in/halt values into a
// scoreboard queue; when both responders return to ready the entry is popped
// and compared, together with the number of cycles each held rdy low.
module tb_d_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        assert0, assert3;
  logic        d_mem_cmd, d_mem_be0, d_mem_be1;
  logic [15:0] d_mem_addr, d_mem_data_out;
  logic [15:0] data_in0, data_in3;
  logic        rdy0, rdy3, halt0, halt3;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic        halt;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  mem_m [logic [15:0]];
  logic [15:0] last_m = 16'h0000;
  logic        halt_m = 1'b0;

  always #5 clk = ~clk;

  d_mem_responder #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .d_mem_assert(assert0), .d_mem_cmd(d_mem_cmd),
    .d_mem_be0(d_mem_be0), .d_mem_be1(d_mem_be1), .d_mem_addr(d_mem_addr),
    .d_mem_data_out(d_mem_data_out), .d_mem_data_in(data_in0),
    .d_mem_rdy(rdy0), .halt(halt0)
  );

  d_mem_responder #(.WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .d_mem_assert(assert3), .d_mem_cmd(d_mem_cmd),
    .d_mem_be0(d_mem_be0), .d_mem_be1(d_mem_be1), .d_mem_addr(d_mem_addr),
    .d_mem_data_out(d_mem_data_out), .d_mem_data_in(data_in3),
    .d_mem_rdy(rdy3), .halt(halt3)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  // Reference behaviour of one access, big-endian word layout.
  task automatic modelAccess(input logic cmd, input logic be0, input logic be1,
                             input logic [15:0] addr, input logic [15:0] data);
    logic [15:0] even_a, odd_a;
    exp_t e;
    even_a = {addr[15:1], 1'b0};
    odd_a  = {addr[15:1], 1'b1};
    if (cmd) begin
      if (even_a == 16'hFFFE) halt_m = 1'b1;
      if (be0 && be1) begin
        mem_m[even_a] = data[15:8];
        mem_m[odd_a]  = data[7:0];
      end else if (be0 != be1) begin
        mem_m[addr] = data[7:0];
      end
    end else begin
      if (be0 && be1) last_m = {mem_m[even_a], mem_m[odd_a]};
      else if (be0 != be1) last_m = {8'h00, mem_m[addr]};
    end
    e.data = last_m;
    e.halt = halt_m;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input string tag, input logic cmd, input logic be0,
                               input logic be1, input logic [15:0] addr,
                               input logic [15:0] data, input bit hold3);
    int   low0 = 0;
    int   low3 = 0;
    bit   done0 = 0;
    bit   done3 = 0;
    int   k = 0;
    exp_t e;
    modelAccess(cmd, be0, be1, addr, data);
    @(negedge clk);
    d_mem_cmd = cmd; d_mem_be0 = be0; d_mem_be1 = be1;
    d_mem_addr = addr; d_mem_data_out = data;
    assert0 = 1'b1; assert3 = 1'b1;
    @(posedge clk);
    #1;
    assert0 = 1'b0;
    if (!hold3) assert3 = 1'b0;
    while ((!done0 || !done3) && k < 40) begin
      if (!done0) begin
        if (!rdy0) low0++; else done0 = 1;
      end
      if (!done3) begin
        if (!rdy3) low3++;
        else begin
          done3 = 1;
          assert3 = 1'b0;
        end
      end
      if (!done0 || !done3) begin
        @(posedge clk);
        #1;
      end
      k++;
    end
    assert3 = 1'b0;
    if (!done0 || !done3) checkOutput({tag, "_timeout"}, 1, 0);
    checkOutput({tag, "_rdylow0"}, low0, 1);
    checkOutput({tag, "_rdylow3"}, low3, 4);
    if (exp_q.size() == 0) begin
      checkOutput({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      checkOutput({tag, "_data0"}, data_in0, e.data);
      checkOutput({tag, "_data3"}, data_in3, e.data);
      checkOutput({tag, "_halt0"}, halt0, e.halt);
      checkOutput({tag, "_halt3"}, halt3, e.halt);
    end
    if (hold3) begin
      // A second acceptance would drop rdy again.
      @(posedge clk);
      #1;
      checkOutput({tag, "_single3"}, rdy3, 1);
    end
  endtask

  initial begin
    rst = 1'b1; assert0 = 1'b0; assert3 = 1'b0;
    d_mem_cmd = 1'b0; d_mem_be0 = 1'b0; d_mem_be1 = 1'b0;
    d_mem_addr = 16'h0000; d_mem_data_out = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_rdy0", rdy0, 1);
    checkOutput("rst_rdy3", rdy3, 1);
    checkOutput("rst_data0", data_in0, 16'h0000);
    checkOutput("rst_data3", data_in3, 16'h0000);
    checkOutput("rst_halt0", halt0, 0);
    checkOutput("rst_halt3", halt3, 0);

    // Requests during reset are refused.
    d_mem_cmd = 1'b1; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'h0050; d_mem_data_out = 16'hDEAD;
    assert0 = 1'b1; assert3 = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_noacc0", rdy0, 1);
    checkOutput("rst_noacc3", rdy3, 1);
    @(negedge clk);
    assert0 = 1'b0; assert3 = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_idle0", rdy0, 1);
    checkOutput("rst_idle3", rdy3, 1);

    applyStimulus("wwr_a0",   1, 1, 1, 16'h00A0, 16'hC000, 0);
    applyStimulus("wrd_a1",   0, 1, 1, 16'h00A1, 16'h0000, 0);
    applyStimulus("wwr_a2",   1, 1, 1, 16'h00A2, 16'h1234, 0);
    applyStimulus("bwr_a3",   1, 0, 1, 16'h00A3, 16'h775A, 0);
    applyStimulus("brd_a3",   0, 0, 1, 16'h00A3, 16'h0000, 0);
    applyStimulus("wrd_a2",   0, 1, 1, 16'h00A2, 16'h0000, 0);
    applyStimulus("brd_a2",   0, 1, 0, 16'h00A2, 16'h0000, 0);
    applyStimulus("bwr_a0",   1, 1, 0, 16'h00A0, 16'h0099, 0);
    applyStimulus("nobe_rd",  0, 0, 0, 16'h00A0, 16'h0000, 0);
    applyStimulus("nobe_wr",  1, 0, 0, 16'h00A2, 16'hFFFF, 0);
    applyStimulus("wrd_a2b",  0, 1, 1, 16'h00A2, 16'h0000, 0);
    applyStimulus("hold_rd",  0, 1, 1, 16'h00A0, 16'h0000, 1);
    applyStimulus("halt_wr",  1, 1, 1, 16'hFFFF, 16'hABCD, 0);
    applyStimulus("halt_rd",  0, 1, 1, 16'hFFFE, 16'h0000, 0);
    applyStimulus("halt_brd", 0, 0, 1, 16'hFFFF, 16'h0000, 0);
    applyStimulus("pre_wr",   1, 1, 1, 16'h0010, 16'h1111, 0);

    // Reset while the write is busy must abort it completely.
    @(negedge clk);
    d_mem_cmd = 1'b1; d_mem_be0 = 1'b1; d_mem_be1 = 1'b1;
    d_mem_addr = 16'h0010; d_mem_data_out = 16'hBEEF;
    assert0 = 1'b1; assert3 = 1'b1;
    @(posedge clk);
    #1;
    assert0 = 1'b0; assert3 = 1'b0; rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_rdy0", rdy0, 1);
    checkOutput("abort_rdy3", rdy3, 1);
    checkOutput("abort_data0", data_in0, 16'h0000);
    checkOutput("abort_data3", data_in3, 16'h0000);
    checkOutput("abort_halt0", halt0, 0);
    checkOutput("abort_halt3", halt3, 0);
    @(negedge clk);
    rst = 1'b0;
    last_m = 16'h0000;
    halt_m = 1'b0;
    applyStimulus("post_rd", 0, 1, 1, 16'h0010, 16'h0000, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/d_mem_responder.md
D_MEM_RESPONDER -- requirements
Module: d_mem_responder

Interface
REQ-001 SHALL provide parameter ADDR_W, default 16, byte-address width; storage = 2^ADDR_W bytes.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 0, range 0..15, extra busy cycles per access.
REQ-003 SHALL provide parameter HALT_ADDR, default 16'hFFFE, write address that raises halt.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- d_mem_assert  input  1  request valid
- d_mem_cmd  input  1  1 = write, 0 = read
- d_mem_be0  input  1  byte enable, even byte
- d_mem_be1  input  1  byte enable, odd byte
- d_mem_addr  input  16  byte address
- d_mem_data_out  input  16  write data from core
- d_mem_data_in  output  16  read data to core, registered
- d_mem_rdy  output  1  1 = idle, request accepted
- halt  output  1  sticky, set by write to HALT_ADDR

Function
REQ-006 SHALL accept a request on a rising edge where d_mem_assert=1 and d_mem_rdy=1; SHALL latch addr, cmd, be0, be1 and data_out at that edge.
REQ-007 SHALL implement FSM IDLE -> BUSY -> IDLE: IDLE on accept goes to BUSY with wait counter = WAIT_CYCLES; BUSY decrements counter each cycle; BUSY at counter=0 performs the access and returns to IDLE.
REQ-008 SHALL drive d_mem_rdy=1 in IDLE and 0 in BUSY; accepted at edge N gives rdy=0 for cycles N+1..N+1+WAIT_CYCLES, and rdy=1 again from edge N+2+WAIT_CYCLES.
REQ-009 SHALL ignore d_mem_assert while BUSY; no second latch, no queueing.
REQ-010 Word access (be0=be1=1) SHALL ignore addr[0]; even byte {addr[15:1],0} <-> data[15:8], odd byte {addr[15:1],1} <-> data[7:0] (big-endian).
REQ-011 Byte access (be0 xor be1) SHALL use full addr; write stores data_out[7:0] to that byte; read returns {8'h00, byte}.
REQ-012 be0=be1=0 SHALL complete with normal timing, no array write, d_mem_data_in unchanged.
REQ-013 Read data SHALL update d_mem_data_in at the access edge and be valid when rdy returns to 1; it SHALL hold until the next read completes.
REQ-014 Writes SHALL update storage only at the access edge; a read issued after rdy returns SHALL return the written value.
REQ-015 halt SHALL set at the access edge of any write whose latched addr[15:1] equals HALT_ADDR[15:1] (any enable pattern); the write also goes to storage; halt stays 1 until reset.
REQ-016 addr bits above ADDR_W SHALL be ignored; storage wraps modulo 2^ADDR_W.

Reset
REQ-017 With rst=1 at a rising edge, SHALL force FSM=IDLE, counter=0, d_mem_rdy=1, d_mem_data_in=16'h0000, halt=0.
REQ-018 Reset mid-BUSY SHALL abort the access: no storage write, no data_in update, no halt set.
REQ-019 Storage contents SHALL NOT be cleared by reset; simulation pre-load only through the bench.
REQ-020 While rst=1, requests SHALL NOT be accepted.

Structure
REQ-021 HALT_ADDR default, FSM state enum and byte-lane constants SHALL live in shared package core_pkg.
REQ-022 SHALL instantiate sub-module dmem_byte_bank (one 8-bit synchronous-write, 2^(ADDR_W-1)-entry array) twice, for even and odd lanes.
REQ-023 Whole block SHALL be 120-400 lines of RTL, no latches, a single clock domain.

Verification
REQ-024 WAIT_CYCLES=0: word write 16'hC000 @ 16'h00A0, then word read @ 16'h00A1 -> data_in=16'hC000, rdy low exactly 1 cycle per access.
REQ-025 Byte write 8'h5A @ 16'h00A3 over word 16'h1234 @ 16'h00A2; byte read @ 16'h00A3 -> 16'h005A; word read @ 16'h00A2 -> 16'h125A.
REQ-026 WAIT_CYCLES=3: read accepted at edge N -> rdy=0 for N+1..N+4, rdy=1 and data valid at N+5; assert held high meanwhile -> exactly one access.
REQ-027 Word write @ 16'hFFFF (be0=be1=1) -> halt=1 after access edge, bytes FFFE/FFFF written; halt stays 1 across further reads.
REQ-028 rst asserted during BUSY of write 16'hBEEF @ 16'h0010 -> next cycle rdy=1, data_in=0, halt=0; later read @ 16'h0010 returns the prior contents.
